// File: rtl/wb_data_mem_pkg.sv
// Shared types and sizing helpers for the Wishbone data memory.
package wb_mem_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_SEL_W  = MAX_DATA_W / 8;

  // Response state machine states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_mem_state_t;

  // Captured bus request; sized for the widest supported data bus
  typedef struct packed {
    logic [31:0]           adr;
    logic                  we;
    logic [MAX_SEL_W-1:0]  sel;
    logic [MAX_DATA_W-1:0] dat;
  } wb_mem_req_t;

  // Byte-offset bits within one word
  function automatic int unsigned lsb_of(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index bits for a given depth
  function automatic int unsigned aw_of(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_data_mem_if.sv
// Wishbone classic bus bundle; signal suffixes are from the slave's view.
interface wb_data_mem_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic              cyc_i;
  logic              stb_i;
  logic [31:0]       adr_i;
  logic              we_i;
  logic [SEL_W-1:0]  sel_i;
  logic [DATA_W-1:0] dat_i;
  logic [DATA_W-1:0] dat_o;
  logic              ack_o;
  logic              err_o;

  modport slave (
    input  cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_data_mem_sram_be.sv
// Byte-enable single-port synchronous array with registered read.
// Kept as a plain wrapper so it can be swapped for a foundry macro.
module sram_be
  import wb_mem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned AW     = aw_of(DEPTH),
  localparam int unsigned SEL_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [SEL_W-1:0]  be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Lane-masked write; the array itself is never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(SEL_W); b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read register updates only on a read strobe and otherwise holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_data_mem.sv
// Wishbone classic slave data memory with programmable wait states.
// Optional build macro WB_DMEM_RANGE_CHECK_EN: out-of-window requests end
// with err_o and leave memory and dat_o untouched; otherwise addresses alias.
module wb_data_mem
  import wb_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic          clk_i,
  input logic          rst_i,
  wb_data_mem_if.slave bus
);

  localparam int unsigned SEL_W     = DATA_W / 8;
  localparam int unsigned LSB       = lsb_of(DATA_W);
  localparam int unsigned AW        = aw_of(DEPTH);
  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

  wb_mem_state_t     state_q;
  logic [CNT_W-1:0]  cnt_q;
  wb_mem_req_t       req_q;
  logic              ack_q;
  logic              err_q;

  wb_mem_req_t       live_req;
  wb_mem_req_t       cur_req;
  logic              req_valid;
  logic              commit;
  logic              in_range;
  logic              mem_we;
  logic              mem_re;
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] rdata;

  assign req_valid = bus.cyc_i & bus.stb_i;

  // Pack the live bus request into the payload struct
  always_comb begin
    live_req     = '0;
    live_req.adr = bus.adr_i;
    live_req.we  = bus.we_i;
    live_req.sel = MAX_SEL_W'(bus.sel_i);
    live_req.dat = MAX_DATA_W'(bus.dat_i);
  end

  // Commit edge: straight from IDLE with no wait states, else last WAIT cycle
  always_comb begin
    commit  = 1'b0;
    cur_req = req_q;
    if (state_q == IDLE) begin
      cur_req = live_req;
      commit  = ZERO_WAIT && req_valid;
    end else if (state_q == WAIT) begin
      commit  = bus.cyc_i && (cnt_q == CNT_W'(1));
    end
    if (rst_i) begin
      commit = 1'b0;
    end
  end

`ifdef WB_DMEM_RANGE_CHECK_EN
  localparam logic [32:0] SPAN    = 33'(DEPTH) * 33'(DATA_W / 8);
  localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI  = WIN_LO + SPAN;
  assign in_range = ({1'b0, cur_req.adr} >= WIN_LO) && ({1'b0, cur_req.adr} < WIN_HI);
`else
  assign in_range = 1'b1;
`endif

  assign mem_idx = cur_req.adr[LSB +: AW];
  assign mem_we  = commit &  cur_req.we & in_range;
  assign mem_re  = commit & ~cur_req.we & in_range;

  sram_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_idx),
    .be_i    (cur_req.sel[SEL_W-1:0]),
    .wdata_i (cur_req.dat[DATA_W-1:0]),
    .rdata_o (rdata)
  );

  // Response FSM: capture in IDLE, count down in WAIT, one cycle in RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q   <= live_req;
            cnt_q   <= WAIT_LOAD;
            state_q <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!bus.cyc_i) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Termination pulses raised on the commit edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= commit &  in_range;
      err_q <= commit & ~in_range;
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = rdata;

`ifdef WB_DMEM_RANGE_CHECK_EN
  assign bus.err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign bus.err_o  = 1'b0;
`endif

  // Address bits outside the index and padding of the wide payload struct
  logic unused_req;
  assign unused_req = ^{cur_req, live_req, req_q};

endmodule

// File: doc/wb_data_mem.md
# wb_data_mem

Parametrised Wishbone classic slave data memory for the SoC core datapath. Successor to the fixed 32-bit, zero-wait data memory:
- generic data width, depth and base address;
- programmable wait states through a response state machine;
- cancellable cycles;
- registered read data aligned with a one-cycle `ack_o`;
- optional out-of-range error termination.

## Interface
Parameters:
- `DATA_W`, 32: bus and word width in bits; one of 32 or 64.
- `DEPTH`, 1024: number of words; power of two.
- `BASE_ADDR`, 32'h0: byte address of word 0; aligned to `DEPTH*DATA_W/8`.
- `WAIT_STATES`, 0: extra cycles inserted before `ack_o`; range 0..15.

Ports:
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cyc_i` in 1: bus cycle.
- `stb_i` in 1: strobe.
- `adr_i` in 32: byte address.
- `we_i` in 1: 1 = write, 0 = read.
- `sel_i` in `DATA_W/8`: byte lane enables.
- `dat_i` in `DATA_W`: write data.
- `dat_o` out `DATA_W`: read data; valid only while `ack_o` is 1.
- `ack_o` out 1: normal termination; one-cycle pulse.
- `err_o` out 1: error termination; one-cycle pulse. Tied 0 when the range check is compiled out.

## Operation
Address decode:
- `LSB = log2(DATA_W/8)`, `AW = log2(DEPTH)`.
- Word index = `adr_i[LSB +: AW]`.
- Low `LSB` bits are ignored; no misalignment handling.

State machine states: IDLE, WAIT, RESP.

IDLE:
- On `cyc_i & stb_i`, capture `adr_i`, `we_i`, `sel_i` and `dat_i` into request registers.
- Load the wait counter with `WAIT_STATES`.
- If `WAIT_STATES == 0`, go to RESP; otherwise go to WAIT.

WAIT:
- Decrement the counter each cycle.
- Go to RESP in the cycle the counter reaches 1.
- If `cyc_i` falls while in WAIT, go to IDLE. No write commits and no termination is issued.

Commit point (the edge that enters RESP):
- Write: lanes with `sel` set are updated; other lanes are untouched.
- Read: `mem[index]` is registered into `dat_o`.
- Read data uses the registered request, not live inputs.

RESP:
- Exactly one of `ack_o` / `err_o` is 1 for exactly one cycle.
- Next state is unconditionally IDLE.
- A strobe still high in the RESP cycle is not sampled. The master must deassert or re-present the strobe, and it is sampled in IDLE.

Other rules:
- `dat_o` holds its value outside RESP and is not cleared.
- Memory contents are not reset.
- Read-after-write to the same word in the next transaction returns the new data.

## Timing
- Reset values: state IDLE, `ack_o` 0, `err_o` 0, `dat_o` 0, counter 0, request registers 0.
- Latency: request sampled in IDLE at cycle N gives termination in cycle `N+1+WAIT_STATES`.
- Throughput: one access per `WAIT_STATES+2` cycles when back-to-back.
- Reset mid-operation: `rst_i` in WAIT or RESP forces IDLE on the next edge. Pending writes are dropped and no termination is issued.
- Reset in the commit-edge cycle takes priority: no write occurs.
- `cyc_i` without `stb_i` does nothing.
- `stb_i` without `cyc_i` does nothing.
- `sel_i == 0` write: no lane changes; `ack_o` is still issued.

## Configuration
Macro: `WB_DMEM_RANGE_CHECK_EN`.

Defined:
- The request is in range if `BASE_ADDR <= adr_i < BASE_ADDR + DEPTH*DATA_W/8`. Compute this in 33 bits; there is no wrap.
- An out-of-range request follows the same state sequence and latency, then terminates with `err_o` instead of `ack_o`.
- An out-of-range write does not modify memory.
- On an out-of-range read, `dat_o` holds its previous value.

Undefined:
- `err_o` is constant 0.
- Address bits above `LSB+AW` are ignored, so memory aliases every `DEPTH*DATA_W/8` bytes.

## Structure
Package `wb_mem_pkg` contains:
- the state enum typedef `wb_mem_state_t` (IDLE, WAIT, RESP);
- the request struct typedef: adr, we, sel, dat;
- localparam helper functions for `LSB` and `AW`.

Sub-module `sram_be`:
- byte-enable synchronous single-port array, parametrised by `DATA_W` and `DEPTH`;
- one write port with lane mask;
- registered read;
- mappable to a foundry macro later.

The top level holds the FSM, wait counter, request registers and range check.

## Test plan
- `WAIT_STATES=0`, 32-bit: write 32'hDEADBEEF to 0x10 with `sel_i=4'hF`, then read 0x10. `ack_o` comes 1 cycle after each request; read returns 32'hDEADBEEF.
- Byte lanes: preload 0x10 = 32'h11223344, write 32'hAABBCCDD with `sel_i=4'b0101`. Read returns 32'h11BB33DD.
- `WAIT_STATES=3`: read is sampled at cycle 10, and `ack_o` is high only in cycle 14. Drop `cyc_i` in cycle 12 on a write: no `ack_o`, and memory is unchanged.
- `DATA_W=64`, `DEPTH=256`: write 64'h0123456789ABCDEF to 0x7F8, read it back, and check word index 255 is used.
- With `WB_DMEM_RANGE_CHECK_EN`, `BASE_ADDR`=0x1000_0000, `DEPTH=1024`:
  - write to 0x1000_1000 gives `err_o` pulse, no `ack_o`;
  - 0x1000_0000 is unchanged;
  - without the macro, the same write aliases to word 0 and gives `ack_o`.
- Assert `rst_i` in WAIT during a write: state returns to IDLE, all outputs are 0, and no write commits.
